// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and constants for the ROM-read / split-accumulate run controller
package accum_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int PUZZLE_COUNT = 200;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-deep valid shift register with synchronous flush and look-ahead occupancy
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic issue,
  output logic acc,
  output logic pending
);
  logic [DEPTH-1:0] q;
  logic [DEPTH-1:0] nxt;
  assign nxt = (q << 1) | DEPTH'(issue);
  assign acc = q[DEPTH-1];
  assign pending = |nxt;
  // shift every cycle; flush drops every in-flight word at once
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= flush ? '0 : nxt;
endmodule

// File: rtl/rom_accum_sequencer.sv
// rom_accum_sequencer: walks ROM addresses 0..count-1 and times accumulator clear/enable/done
module rom_accum_sequencer
  import accum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              pause,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              issue_vld,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              busy,
  output logic              done
);
  state_t state, state_nx;
  logic [ADDR_W:0] addr, cnt;
  logic pending, kill, last;
  assign kill = abort && state != IDLE;
  assign last = addr + (ADDR_W + 1)'(1) == cnt;
  assign issue_vld = state == ISSUE && !pause;
  assign acc_clr = state == CLEAR;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rom_addr = addr[ADDR_W-1:0];
  // state, latched count and address counter (one bit wider so 2^ADDR_W words never wrap)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !abort) cnt <= count;
      addr <= acc_clr ? '0 : issue_vld ? addr + (ADDR_W + 1)'(1) : addr;
    end
  // next state; abort overrides everything, including a start seen in IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start ? CLEAR : IDLE;
      CLEAR: state_nx = cnt == '0 ? DRAIN : ISSUE;
      ISSUE: state_nx = issue_vld && last ? DRAIN : ISSUE;
      DRAIN: state_nx = pending ? DRAIN : DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  valid_delay_line #(.DEPTH(PIPE_LAT)) u_vdl (
    .clk(clk),
    .rst(rst),
    .flush(kill),
    .issue(issue_vld),
    .acc(acc_en),
    .pending(pending)
  );
endmodule

// File: tb/tb_rom_accum_sequencer.sv
// tb_rom_accum_sequencer: scoreboard bench for the ROM accumulate run controller
module tb_rom_accum_sequencer;
  import accum_pkg::*;
  localparam int AW = 8;
  logic clk = 0, rst = 1, start = 0, pause = 0, abort = 0;
  logic [AW:0] count = '0;
  logic [AW-1:0] rom_addr;
  logic issue_vld, acc_clr, acc_en, busy, done;
  logic start3 = 0;
  logic [AW:0] count3 = '0;
  logic [AW-1:0] rom_addr3;
  logic issue_vld3, acc_clr3, acc_en3, busy3, done3;
  int pass_cnt = 0, tot = 0;
  longint cyc = 0;
  logic [31:0] data_q, acc_m;

  typedef struct {
    int cnt;
    longint done_cyc;
    logic [31:0] sum;
    int busy_cyc;
  } run_t;
  run_t run_q[$];
  run_t mr;
  int addr_q[$];
  int n_iss = 0, n_acc = 0, n_clr = 0, n_busy = 0;

  rom_accum_sequencer #(.ADDR_W(AW), .PIPE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .pause(pause), .abort(abort),
    .rom_addr(rom_addr), .issue_vld(issue_vld), .acc_clr(acc_clr), .acc_en(acc_en),
    .busy(busy), .done(done)
  );
  rom_accum_sequencer #(.ADDR_W(AW), .PIPE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .count(count3), .pause(1'b0), .abort(1'b0),
    .rom_addr(rom_addr3), .issue_vld(issue_vld3), .acc_clr(acc_clr3), .acc_en(acc_en3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
    return ({24'd0, a} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic void chk(input string nm, input longint act, input longint exp);
    tot++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // reference ROM + data register + accumulator driven by the sequencer's controls
  always @(posedge clk) begin
    data_q <= rom_fn(rom_addr);
    if (acc_clr) acc_m <= '0;
    else if (acc_en) acc_m <= acc_m + data_q;
  end

  // monitor: pops expected addresses on issue and expected run results on done
  always @(negedge clk) begin
    if (!busy) begin
      n_iss = 0; n_acc = 0; n_clr = 0; n_busy = 0;
      if (issue_vld || acc_en || done || acc_clr) chk("idle_outputs_quiet", 1, 0);
    end else begin
      n_busy++;
      if (acc_clr) n_clr++;
      if (acc_en) n_acc++;
      if (issue_vld) begin
        n_iss++;
        if (addr_q.size() == 0) chk("issue_unexpected", rom_addr, -1);
        else chk("issue_addr", rom_addr, addr_q.pop_front());
      end
      if (done) begin
        if (run_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mr = run_q.pop_front();
          chk("run_issues", n_iss, mr.cnt);
          chk("run_acc_en", n_acc, mr.cnt);
          chk("run_acc_clr", n_clr, 1);
          chk("run_done_cycle", cyc, mr.done_cyc);
          chk("run_busy_cycles", n_busy, mr.busy_cyc);
          chk("run_sum", acc_m, mr.sum);
        end
      end
    end
  end

  // c words; pa>=0 pauses 5 cycles after addr pa issues; ab>=0 aborts as addr ab issues;
  // st_at>0 pulses start with count=3 in that cycle of the run
  task automatic run(input int c, input int pa, input int ab, input int st_at);
    logic [31:0] s = '0;
    int ext = pa >= 0 ? 5 : 0;
    int na = 0, nd = 0;
    bit fin = 0;
    for (int i = 0; i < c; i++) s += rom_fn(AW'(i));
    @(negedge clk);
    start = 1;
    count = (AW + 1)'(c);
    if (ab < 0) run_q.push_back('{c, cyc + c + 3 + ext, s, c + 3 + ext});
    for (int i = 0; i < (ab < 0 ? c : ab + 1); i++) addr_q.push_back(i);
    for (int k = 1; k < 2000 && !fin; k++) begin
      @(negedge clk);
      if (done) fin = 1;
      else if (ab >= 0 && k == ab + 3) begin
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_issue", issue_vld, 0);
        chk("abort_acc_en", acc_en, 0);
        fin = 1;
      end else begin
        start = k == st_at;
        if (k == st_at) count = 9'd3;
        pause = pa >= 0 && k >= pa + 3 && k < pa + 8;
        abort = ab >= 0 && k == ab + 2;
      end
    end
    if (!fin) chk("run_timeout", 1, 0);
    start = 0;
    pause = 0;
    abort = 0;
    if (ab >= 0) begin
      repeat (10) begin
        @(negedge clk);
        na += int'(acc_en);
        nd += int'(done);
      end
      chk("post_abort_acc_en", na, 0);
      chk("post_abort_done", nd, 0);
      chk("post_abort_addr_q", addr_q.size(), 0);
    end
  endtask

  // PIPE_LAT=3 instance: acc_en must equal issue_vld three cycles earlier
  task automatic sweep3(input int c);
    logic [2:0] h = '0;
    int ni = 0, na = 0;
    bit fin = 0;
    @(negedge clk);
    start3 = 1;
    count3 = (AW + 1)'(c);
    for (int k = 1; k < 100 && !fin; k++) begin
      @(negedge clk);
      start3 = 0;
      chk("p3_acc_en_delay", acc_en3, h[2]);
      h = {h[1:0], issue_vld3};
      ni += int'(issue_vld3);
      na += int'(acc_en3);
      if (done3) begin
        chk("p3_done_cycle", k, c + 5);
        fin = 1;
      end
    end
    if (!fin) chk("p3_timeout", 1, 0);
    chk("p3_issues", ni, c);
    chk("p3_acc_en", na, c);
  endtask

  task automatic async_reset_mid_run();
    @(negedge clk);
    start = 1;
    count = 9'd50;
    for (int i = 0; i < 50; i++) addr_q.push_back(i);
    repeat (10) begin
      @(negedge clk);
      start = 0;
    end
    chk("pre_rst_issuing", issue_vld, 1);
    #2 rst = 1;
    #1;
    chk("rst_issue", issue_vld, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_clr_done", {acc_clr, done}, 0);
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_acc_en", acc_en, 0);
  endtask

  initial begin
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {issue_vld, acc_clr, acc_en, done}, 0);
    chk("reset_addr", rom_addr, 0);
    chk("reset_busy3", busy3, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    abort = 1;
    start = 1;
    count = 9'd4;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    start = 0;
    abort = 0;
    run(PUZZLE_COUNT, -1, -1, -1);
    run(0, -1, -1, -1);
    run(10, 3, -1, -1);
    run(50, -1, 20, -1);
    run(5, -1, -1, -1);
    run(256, -1, -1, 50);
    sweep3(6);
    async_reset_mid_run();
    run(4, -1, -1, -1);
    repeat (3) @(negedge clk);
    chk("runs_drained", run_q.size(), 0);
    chk("addrs_drained", addr_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
